instr_encoder_loader: RTL and testbench

//  Packs field-level RISC-V instruction requests (opcode, rd, rs1, rs2, funct3, funct7, imm) into 32-bit RV32I words.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/instr_pack.sv | 55 +++++
 rtl/instr_encoder_loader.sv | 140 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions used by the instruction encoder/loader and the
// opcode decoder: instruction-format codes, base opcodes and a helper that
// checks whether an opcode belongs to a given format.
// ----------------------------------------------------------------------------
package riscv_pkg;

  // Instruction format codes as carried on fmt_i; 6 and 7 are invalid.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] R_TYPE       = 7'h33;
  localparam logic [6:0] I_TYPE_LOGIC = 7'h13;
  localparam logic [6:0] I_TYPE_JUMP  = 7'h67;
  localparam logic [6:0] U_TYPE       = 7'h37;
  localparam logic [6:0] B_TYPE       = 7'h63;
  localparam logic [6:0] S_TYPE       = 7'h23;
  localparam logic [6:0] I_TYPE_LOAD  = 7'h03;
  localparam logic [6:0] J_TYPE       = 7'h6F;

  // True when op is one of the supported opcodes and matches fmt.
  function automatic logic opcode_fits_fmt(input logic [2:0] fmt,
                                           input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_R:   ok = (op == R_TYPE);
      FMT_I:   ok = (op == I_TYPE_LOGIC) || (op == I_TYPE_JUMP) ||
                    (op == I_TYPE_LOAD);
      FMT_S:   ok = (op == S_TYPE);
      FMT_B:   ok = (op == B_TYPE);
      FMT_U:   ok = (op == U_TYPE);
      FMT_J:   ok = (op == J_TYPE);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// ----------------------------------------------------------------------------
// instr_pack
// Purely combinational RV32I field packer: assembles opcode/register/funct/
// immediate fields into a 32-bit instruction word for formats R, I, S, B, U, J.
// Optional build macro: ILLEGAL_OPCODE_CHECK_EN - when defined, valid_o also
// requires the opcode to be a supported one consistent with fmt_i.
// Ports:
//   fmt_i      format code (0=R 1=I 2=S 3=B 4=U 5=J, 6..7 invalid)
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i  instruction fields
//   word_o     packed instruction (0 when fmt_i is invalid)
//   valid_o    request may be written
// ----------------------------------------------------------------------------
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic fmt_ok;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    word_o = '0;
    fmt_ok = 1'b1;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      // Branch/jump immediates are byte offsets; bit 0 is implicitly zero.
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       rd_i, opcode_i};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ILLEGAL_OPCODE_CHECK_EN
  assign valid_o = fmt_ok && opcode_fits_fmt(fmt_i, opcode_i);
`else
  assign valid_o = fmt_ok;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts field-level RV32I instruction requests, packs them into 32-bit words
// and writes them sequentially to an instruction-memory write port starting
// at BASE_ADDR. Used by boot/self-test logic to load programs.
// Optional build macro: ILLEGAL_OPCODE_CHECK_EN (opcode legality/consistency
// check inside instr_pack; violations are flagged like an invalid format).
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   start_i            synchronous clear of load pointer, count and error
//   req_valid_i/req_ready_o  request handshake
//   fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i  fields
//   mem_we_o, mem_addr_o, mem_wdata_o  memory write port (one-cycle strobe)
//   count_o            words written since reset/start
//   full_o             count_o == DEPTH
//   err_o              sticky invalid-request flag
// ----------------------------------------------------------------------------
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    fmt_i,
  input  logic [6:0]    opcode_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [2:0]    funct3_i,
  input  logic [6:0]    funct7_i,
  input  logic [31:0]   imm_i,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          err_o
);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   pack_word;
  logic          pack_valid;
  logic          accept;

  instr_pack u_pack (
    .fmt_i    (fmt_i),
    .opcode_i (opcode_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .word_o   (pack_word),
    .valid_o  (pack_valid)
  );

  assign full_o = (count_q == DEPTH_C);
  // Gated by reset so the handshake is closed while reset is held.
  assign req_ready_o = reset && (state_q == ST_IDLE) && !full_o && !start_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          if (pack_valid) begin
            wdata_d = pack_word;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        // A start during the write lets the strobe finish but discards the
        // increment, so the pointer lands on 0 rather than 1.
        if (start_i) begin
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobe decoded straight from the state register so an async reset
  // drops it immediately.
  assign mem_we_o    = (state_q == ST_WRITE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Self-checking bench for instr_encoder_loader (DEPTH=4). A behavioural model
// builds expected words from the RV32I field layout with shifts and masks and
// tracks the expected count and error flag.
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [2:0]  count_o;
  logic        full_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int m_count  = 0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .err_o       (err_o)
  );

  // Reference encoder: places each field at its architectural bit position.
  function automatic logic [31:0] model_word(input int f, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = op | (f3 << 12) | (rs1 << 15);
    case (f)
      0: return base | (rd << 7) | (rs2 << 20) | (f7 << 25);
      1: return base | (rd << 7) | ((imm & 32'hFFF) << 20);
      2: return base | ((imm & 31) << 7) | (rs2 << 20) | (((imm >> 5) & 127) << 25);
      3: return base | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) |
                (rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      4: return op | (rd << 7) | (imm & 32'hFFFF_F000);
      5: return op | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20) |
                (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request and wait (bounded) for acceptance.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, output bit accepted);
    @(negedge clk);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; req_valid_i = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready_o) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  // Observe the write cycle following an accept and the cycle after it.
  task automatic observe_write(input string name, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data);
    @(negedge clk);
    checks++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== exp_addr || mem_wdata_o !== exp_data) begin
      failures++;
      $display("FAIL %s: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
               name, mem_we_o, mem_addr_o, mem_wdata_o, exp_addr, exp_data);
    end
    m_count++;
    @(negedge clk);
    checks++;
    if (mem_we_o !== 1'b0 || count_o !== 3'(m_count)) begin
      failures++;
      $display("FAIL %s_after: we=%b count=%0d, expected we=0 count=%0d",
               name, mem_we_o, count_o, m_count);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL start_ready: ready=%b, expected 0", req_ready_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    m_count = 0; m_err = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || err_o !== 1'b0 || full_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL start_clear: count=%0d err=%b full=%b ready=%b, expected 0 0 0 1",
               count_o, err_o, full_o, req_ready_o);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (req_ready_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== BASE ||
        mem_wdata_o !== 32'h0 || count_o !== 3'd0 || full_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b we=%b addr=%h data=%h count=%0d full=%b err=%b, expected reset values",
               name, req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, count_o, full_o, err_o);
    end
  endtask

  task automatic test_reset();
    #13;
    check_reset_values("reset_values");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: ready=%b, expected 1", req_ready_o);
    end
  endtask

  task automatic test_r_type();
    bit acc;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, acc);
    observe_write("add", BASE, 32'h0020_81B3);
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_start();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, acc);
    observe_write("addi", BASE, 32'h0050_0093);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, acc);
    observe_write("sw", BASE + 32'd4, 32'h0020_A423);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, acc);
    observe_write("beq", BASE + 32'd8, 32'h0020_8463);
  endtask

  task automatic test_u_j();
    bit acc;
    do_start();
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, acc);
    observe_write("lui", BASE, 32'h1234_52B7);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, acc);
    observe_write("jal", BASE + 32'd4, 32'h0100_00EF);
  endtask

  task automatic test_full();
    bit acc;
    do_start();
    for (int k = 0; k < 4; k++) begin
      send(3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), acc);
      observe_write("fill", BASE + 32'(4 * k), model_word(1, 7'h13, k, 0, 0, 0, 0, k));
    end
    send(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, acc);
    checks++;
    if (acc !== 1'b0 || full_o !== 1'b1 || req_ready_o !== 1'b0 || count_o !== 3'd4 ||
        mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL full: accepted=%b full=%b ready=%b count=%0d we=%b, expected 0 1 0 4 0",
               acc, full_o, req_ready_o, count_o, mem_we_o);
    end
    do_start();
  endtask

  task automatic test_invalid_fmt();
    bit acc;
    send(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, acc);
    @(negedge clk);
    checks++;
    if (acc !== 1'b1 || err_o !== 1'b1 || mem_we_o !== 1'b0 || count_o !== 3'd0 ||
        req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL invalid_fmt: accepted=%b err=%b we=%b count=%0d ready=%b, expected 1 1 0 0 1",
               acc, err_o, mem_we_o, count_o, req_ready_o);
    end
    do_start();
`ifdef ILLEGAL_OPCODE_CHECK_EN
    send(3'd0, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, acc);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || mem_we_o !== 1'b0 || count_o !== 3'd0) begin
      failures++;
      $display("FAIL illegal_opcode: err=%b we=%b count=%0d, expected 1 0 0",
               err_o, mem_we_o, count_o);
    end
    do_start();
`endif
  endtask

  task automatic test_start_in_write();
    bit acc;
    send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0, acc);
    @(negedge clk);
    start_i = 1'b1;
    checks++;
    if (mem_we_o !== 1'b1) begin
      failures++;
      $display("FAIL start_in_write_we: we=%b, expected 1", mem_we_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || mem_we_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL start_in_write: count=%0d we=%b err=%b, expected 0 0 0",
               count_o, mem_we_o, err_o);
    end
    m_count = 0;
  endtask

  task automatic test_random();
    bit acc;
    logic [6:0] ops_i [3];
    logic [6:0] op;
    logic [31:0] imm, exp_w;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    int f;
    ops_i[0] = 7'h13; ops_i[1] = 7'h67; ops_i[2] = 7'h03;
    for (int n = 0; n < 20; n++) begin
      if (m_count == DEPTH) do_start();
      f = int'($urandom_range(0, 6));
      if (f == 6) f = 6 + int'($urandom_range(0, 1));
      case (f)
        0: op = 7'h33;
        1: op = ops_i[$urandom_range(0, 2)];
        2: op = 7'h23;
        3: op = 7'h63;
        4: op = 7'h37;
        5: op = 7'h6F;
        default: op = 7'($urandom);
      endcase
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom); imm = $urandom;
      send(3'(f), op, rd, rs1, rs2, f3, f7, imm, acc);
      if (f <= 5) begin
        exp_w = model_word(f, op, rd, rs1, rs2, f3, f7, imm);
        observe_write("random", BASE + 32'(4 * m_count), exp_w);
      end else begin
        m_err = 1'b1;
        @(negedge clk);
        checks++;
        if (err_o !== m_err || mem_we_o !== 1'b0 || count_o !== 3'(m_count)) begin
          failures++;
          $display("FAIL random_invalid: err=%b we=%b count=%0d, expected 1 0 %0d",
                   err_o, mem_we_o, count_o, m_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit acc;
    send(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, acc);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_values("reset_mid_write");
    @(negedge clk);
    reset = 1'b1;
    m_count = 0; m_err = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || count_o !== 3'd0 || mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_mid_write: ready=%b count=%0d we=%b, expected 1 0 0",
               req_ready_o, count_o, mem_we_o);
    end
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b0; req_valid_i = 1'b0;
    fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0; imm_i = '0;
    test_reset();
    test_r_type();
    test_back_to_back();
    test_u_j();
    test_full();
    test_invalid_fmt();
    test_start_in_write();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
